muldiv_unit: RTL
================

# muldiv_unit

Multi-cycle HI/LO multiply/divide unit for the 5-stage MIPS pipeline, sitting beside the EX-stage ALU. It executes MULT/MULTU/DIV/DIVU plus MFHI/MFLO/MTHI/MTLO, owns the HI/LO registers, and drives a stall request into the hazard unit. This is the opposite direction of the hazard interface: a stall *source* rather than a stall *consumer*.

## Interface
- `DIV_CYCLES`, default 32: iterations per divide (one quotient bit per cycle); must equal the data width.
- `clk`  in  1  : single clock. All state updates on the rising edge.
- `rst`  in  1  : asynchronous, active-high reset.
- `StartE`  in  1  : a valid op is in EX. Caller already masks it with FlushE.
- `OpE`  in  4  : op code; values are defined in the package.
- `SrcAE`  in  32  : rs operand (dividend / multiplicand / MTHI/MTLO source).
- `SrcBE`  in  32  : rt operand (divisor / multiplier).
- `MdStallReq`  out  1  : to the hazard unit. When high, F/D/E are held and a bubble is inserted into M.
- `BusyE`  out  1  : an iterative operation is in progress.
- `ResultE`  out  32  : HI (MFHI) or LO (MFLO), combinational. Otherwise 0.
- `Hi`, `Lo`  out  32  : architectural registers, for debug.

## Operation
- State machine with two states: IDLE and BUSY. A 6-bit iteration counter runs only in BUSY.
- **Accept.** An op is accepted on an edge where StartE=1, OpE≠MD_NONE, and MdStallReq=0.
- **Mult/div in IDLE.**
  - Latch operand magnitudes and the sign flags.
  - Clear the counter and go to BUSY.
- **BUSY.**
  - Advance one iteration per cycle.
  - At the end of iteration DIV_CYCLES, write HI/LO and return to IDLE.
- **MTHI/MTLO in IDLE.** Write HI or LO from SrcAE at the accept edge.
- **MFHI/MFLO.** No state change; ResultE is valid in the same cycle.
- **MdStallReq = BusyE & StartE & (OpE≠MD_NONE).** Any HI/LO op that arrives while busy is held in EX.
- **Signed ops.** Operate on magnitudes, then correct the result signs.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - MULT HI:LO is the full 64-bit two's-complement product.
- **Boundary cases.**
  - Divide by zero (DIV/DIVU): LO=0xFFFFFFFF, HI=dividend. Latency is unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- **Reset.** Asserting `rst` at any time, including mid-operation, aborts the operation. Hi=Lo=0, state IDLE, counter 0, BusyE=0, MdStallReq=0.

## Timing
- Accept at edge 0. BusyE is high in cycles 1..32. HI/LO are written at edge 32, and BusyE falls at edge 32.
- An op waiting in EX is stalled through cycle 32 and accepted/completes at edge 33.
- MFHI/MFLO issued in the cycle right after an accept reads the new value in cycle 33.
- Back-to-back mult/div: the second one is accepted 33 cycles after the first.
- Reset values: Hi=Lo=0, BusyE=0, MdStallReq=0, ResultE=0.

## Configuration
- **`MULDIV_FASTMUL_EN` defined.** MULT/MULTU write HI/LO at the accept edge through a single-cycle 32×32 multiply. BusyE stays low, so there is no stall.
- **Macro undefined.** Multiply uses iterative shift-add, one bit per cycle. Latency and stall behaviour are identical to divide (32 busy cycles).
- Divide is always iterative.

## Structure
- **Package `muldiv_pkg`.**
  - Op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8.
  - State encoding: IDLE=0, BUSY=1.
  - Constant WORD_W=32.
- **Sub-module `md_div_iter`.**
  - Unsigned restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - Sign handling and the divide-by-zero / overflow override stay in the wrapper.

## Test plan
- **MULT.** MULT 0xFFFFFFFE × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. BusyE high 32 cycles without the macro, 0 cycles with it.
- **DIVU with waiting MFLO.** DIVU 100/7, then MFLO in the next cycle → MdStallReq high in cycles 1..32, ResultE=14 at cycle 33, HI=2.
- **DIV signed.** DIV 0xFFFFFFF9 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Divide by zero.** DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- **Signed overflow.** DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **Reset mid-divide.** Assert rst in cycle 10 of a divide → BusyE=0 immediately, Hi=Lo=0. A following MFHI returns 0 with no stall.
- **MTHI then busy collision.** MTHI 0x1234, then MFHI → ResultE=0x1234 with no stall. A MULT issued while a DIV is busy stalls and is accepted at edge 33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM encoding, word width and result types shared by
// the HI/LO multiply/divide unit and its iterative divider.
package muldiv_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] hi;
        logic [WORD_W-1:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set; used for sign correction of
    // magnitude results.
    function automatic logic [WORD_W-1:0] negate_if(input logic neg,
                                                     input logic [WORD_W-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// md_div_iter: unsigned restoring divider, one quotient bit per cycle.
// i_start loads the operands; o_done is high during the cycle whose closing
// edge retires the last bit, and o_quotient/o_remainder then carry the final
// result (they always show the value the current step will produce).
module md_div_iter
    import muldiv_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder,
    output logic         o_done
);

    logic         r_active;
    logic [5:0]   r_cnt;
    logic [W-1:0] r_quot;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_divisor;

    logic [W:0]   w_shift;
    logic [W-1:0] w_sub;
    logic         w_ge;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    assign w_shift     = {r_rem, r_quot[W-1]};
    assign w_ge        = (w_shift >= {1'b0, r_divisor});
    assign w_sub       = w_shift[W-1:0] - r_divisor;
    assign o_quotient  = {r_quot[W-2:0], w_ge};
    assign o_remainder = w_ge ? w_sub : w_shift[W-1:0];
    assign o_done      = r_active && (r_cnt == 6'(W - 1));

    // Load operands on start, then retire one quotient bit per cycle.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_cnt     <= '0;
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
        end else if (r_active) begin
            r_quot <= o_quotient;
            r_rem  <= o_remainder;
            r_cnt  <= r_cnt + 6'd1;
            if (o_done) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit beside the EX-stage ALU. Executes
// MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, owns HI/LO and raises MdStallReq
// when a HI/LO op reaches EX while an iterative op is still running.
// Build option: MULDIV_FASTMUL_EN selects a single-cycle multiply that writes
// HI/LO at the accept edge; without it multiply is iterative shift-add with
// the same 32-cycle busy window as divide.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StartE,
    input  logic [3:0]        OpE,
    input  logic [WORD_W-1:0] SrcAE,
    input  logic [WORD_W-1:0] SrcBE,
    output logic              MdStallReq,
    output logic              BusyE,
    output logic [WORD_W-1:0] ResultE,
    output logic [WORD_W-1:0] Hi,
    output logic [WORD_W-1:0] Lo
);

    localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 1);

    md_op_e            w_op;
    md_state_e         r_state;
    md_state_e         w_state_next;
    logic              w_valid;
    logic              w_accept;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_signed;
    logic              w_start_iter;
    logic              w_done;
    logic [WORD_W-1:0] w_a_mag;
    logic [WORD_W-1:0] w_b_mag;

    logic [WORD_W-1:0] r_hi;
    logic [WORD_W-1:0] r_lo;
    logic [WORD_W-1:0] r_dividend;
    logic [5:0]        r_cnt;
    logic              r_is_div;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_div_zero;
    logic              r_div_ovf;

    logic [WORD_W-1:0] w_quot;
    logic [WORD_W-1:0] w_rem;
    logic              w_div_done;
    hilo_t             w_div_res;
    hilo_t             w_final;

    // Decode, accept and stall: a valid op is held in EX while busy.
    assign w_op       = md_op_e'(OpE);
    assign w_valid    = StartE && (w_op != MD_NONE);
    assign BusyE      = (r_state == ST_BUSY);
    assign MdStallReq = BusyE && w_valid;
    assign w_accept   = w_valid && !MdStallReq;
    assign w_is_mul   = (w_op == MD_MULT) || (w_op == MD_MULTU);
    assign w_is_div   = (w_op == MD_DIV) || (w_op == MD_DIVU);
    assign w_signed   = (w_op == MD_MULT) || (w_op == MD_DIV);
    assign w_a_mag    = (w_signed && SrcAE[WORD_W-1]) ? -SrcAE : SrcAE;
    assign w_b_mag    = (w_signed && SrcBE[WORD_W-1]) ? -SrcBE : SrcBE;

`ifdef MULDIV_FASTMUL_EN
    logic [2*WORD_W-1:0] w_fast_prod;

    // Sign- or zero-extend to full width so the truncated product is exact.
    assign w_fast_prod = (w_op == MD_MULT)
        ? {{WORD_W{SrcAE[WORD_W-1]}}, SrcAE} * {{WORD_W{SrcBE[WORD_W-1]}}, SrcBE}
        : {{WORD_W{1'b0}}, SrcAE} * {{WORD_W{1'b0}}, SrcBE};
    assign w_start_iter = w_accept && w_is_div;
    assign w_final      = w_div_res;
`else
    logic [WORD_W-1:0]   r_mcand;
    logic [2*WORD_W-1:0] r_prod;
    logic [WORD_W:0]     w_psum;
    logic [2*WORD_W-1:0] w_prod_next;
    hilo_t               w_mul_res;

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole product right.
    assign w_psum       = {1'b0, r_prod[2*WORD_W-1:WORD_W]}
                        + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next  = {w_psum, r_prod[WORD_W-1:1]};
    assign w_mul_res    = r_neg_q ? -w_prod_next : w_prod_next;
    assign w_start_iter = w_accept && (w_is_div || w_is_mul);
    assign w_final      = r_is_div ? w_div_res : w_mul_res;
`endif

    md_div_iter #(
        .W (WORD_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_accept && w_is_div),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_quotient  (w_quot),
        .o_remainder (w_rem),
        .o_done      (w_div_done)
    );

    assign w_done = r_is_div ? w_div_done : (r_cnt == LAST_ITER);

    // Sign-correct the divider result and apply the divide-by-zero and
    // most-negative / -1 overrides.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_div_res.lo = negate_if(r_neg_q, w_quot);
        w_div_res.hi = negate_if(r_neg_r, w_rem);
        if (r_div_zero) begin
            w_div_res.lo = '1;
            w_div_res.hi = r_dividend;
        end else if (r_div_ovf) begin
            w_div_res.lo = {1'b1, {(WORD_W-1){1'b0}}};
            w_div_res.hi = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: enter BUSY on an iterative accept, leave on the last iteration.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_iter) w_state_next = ST_BUSY;
            ST_BUSY: if (w_done)       w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // HI/LO writes, operand latching and the iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_dividend <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
`ifndef MULDIV_FASTMUL_EN
            r_mcand    <= '0;
            r_prod     <= '0;
`endif
        end else begin
            if (w_accept && (w_op == MD_MTHI)) r_hi <= SrcAE;
            if (w_accept && (w_op == MD_MTLO)) r_lo <= SrcAE;
`ifdef MULDIV_FASTMUL_EN
            if (w_accept && w_is_mul) {r_hi, r_lo} <= w_fast_prod;
`endif
            if (w_start_iter) begin
                r_cnt      <= '0;
                r_is_div   <= w_is_div;
                r_neg_q    <= w_signed && (SrcAE[WORD_W-1] ^ SrcBE[WORD_W-1]);
                r_neg_r    <= w_signed && SrcAE[WORD_W-1];
                r_div_zero <= w_is_div && (SrcBE == '0);
                r_div_ovf  <= (w_op == MD_DIV) && (SrcAE == {1'b1, {(WORD_W-1){1'b0}}})
                              && (SrcBE == '1);
                r_dividend <= SrcAE;
`ifndef MULDIV_FASTMUL_EN
                r_mcand    <= w_a_mag;
                r_prod     <= {{WORD_W{1'b0}}, w_b_mag};
`endif
            end else if (BusyE) begin
                r_cnt <= r_cnt + 6'd1;
`ifndef MULDIV_FASTMUL_EN
                r_prod <= w_prod_next;
`endif
                if (w_done) begin
                    {r_hi, r_lo} <= w_final;
                    r_cnt        <= '0;
                end
            end
        end
    end

    // MFHI/MFLO read path, zero for every other op.
    always_comb begin
        ResultE = '0;
        if (StartE && (w_op == MD_MFHI)) begin
            ResultE = r_hi;
        end else if (StartE && (w_op == MD_MFLO)) begin
            ResultE = r_lo;
        end
    end

    assign Hi = r_hi;
    assign Lo = r_lo;

endmodule
